// File: rtl/mips_rf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_rf_pkg
// Brief    : Shared register-file constants and the register address type.
// Revision : 1.0 - initial release
// ============================================================================
package mips_rf_pkg;

    localparam int NREGS = 32;
    localparam int AW    = 5;
    localparam int W     = 32;

    typedef logic [AW-1:0] reg_addr_t;

endpackage
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : regfile_scoreboard
// Brief    : One busy bit per register; set/clear/flush plus two lookup ports.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_scoreboard
    import mips_rf_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      set_en,
    input  reg_addr_t set_addr,
    input  logic      clr_en,
    input  reg_addr_t clr_addr,
    input  logic      flush,
    input  reg_addr_t lk_a_addr,
    output logic      lk_a_busy,
    input  reg_addr_t lk_b_addr,
    output logic      lk_b_busy
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // Order matters: set overrides a same-index clear, flush overrides both.
    always_comb begin
        busy_d = busy_q;
        if (clr_en) begin
            busy_d[clr_addr] = 1'b0;
        end
        if (set_en && (set_addr != '0)) begin
            busy_d[set_addr] = 1'b1;
        end
        if (flush) begin
            busy_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign lk_a_busy = busy_q[lk_a_addr];
    assign lk_b_busy = busy_q[lk_b_addr];

endmodule
`default_nettype wire

// File: rtl/regfile_read_unit.sv
`default_nettype none
// ============================================================================
// Module   : regfile_read_unit
// Brief    : Two-operand register read with valid/ready, 1-cycle latency and
//            a busy-bit scoreboard that stalls reads of pending writes.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_read_unit
    import mips_rf_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREGS*W-1:0]   regs_flat,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [AW-1:0]        req_rs,
    input  logic [AW-1:0]        req_rt,
    input  logic                 req_dst_vld,
    input  logic [AW-1:0]        req_dst,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [W-1:0]         rsp_rs_data,
    output logic [W-1:0]         rsp_rt_data,
    input  logic                 flush
);

    logic [W-1:0] regs_arr [NREGS];

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_unpack
            assign regs_arr[gi] = regs_flat[gi*W +: W];
        end
    endgenerate

    logic         rs_busy;
    logic         rt_busy;
    logic         hazard;
    logic         accept;
    logic         rsp_valid_q;
    logic         rsp_valid_d;
    logic [W-1:0] rs_data_q;
    logic [W-1:0] rs_data_d;
    logic [W-1:0] rt_data_q;
    logic [W-1:0] rt_data_d;

    regfile_scoreboard u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .set_en    (accept && req_dst_vld),
        .set_addr  (req_dst),
        .clr_en    (wr_en),
        .clr_addr  (wr_addr),
        .flush     (flush),
        .lk_a_addr (req_rs),
        .lk_a_busy (rs_busy),
        .lk_b_addr (req_rt),
        .lk_b_busy (rt_busy)
    );

    // A write landing this cycle is already in regs_flat at the posedge.
    assign hazard = (rs_busy && !(wr_en && (wr_addr == req_rs)))
                  | (rt_busy && !(wr_en && (wr_addr == req_rt)));

    assign req_ready = !hazard && !flush && (!rsp_valid_q || rsp_ready);
    assign accept    = req_valid && req_ready;

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rs_data_d   = rs_data_q;
        rt_data_d   = rt_data_q;
        if (accept) begin
            rs_data_d = (req_rs == '0) ? '0 : regs_arr[req_rs];
            rt_data_d = (req_rt == '0) ? '0 : regs_arr[req_rt];
        end
        if (flush) begin
            rsp_valid_d = 1'b0;
        end else if (accept) begin
            rsp_valid_d = 1'b1;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_q <= 1'b0;
            rs_data_q   <= '0;
            rt_data_q   <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rs_data_q   <= rs_data_d;
            rt_data_q   <= rt_data_d;
        end
    end

    assign rsp_valid   = rsp_valid_q;
    assign rsp_rs_data = rs_data_q;
    assign rsp_rt_data = rt_data_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_read_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_read_unit
// Brief    : Self-checking bench for regfile_read_unit with a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_read_unit;
    import mips_rf_pkg::*;

    logic               clk = 1'b0;
    logic               reset;
    logic [NREGS*W-1:0] regs_flat;
    logic               wr_en;
    logic [AW-1:0]      wr_addr;
    logic [W-1:0]       wr_data;
    logic               req_valid;
    logic               req_ready;
    logic [AW-1:0]      req_rs;
    logic [AW-1:0]      req_rt;
    logic               req_dst_vld;
    logic [AW-1:0]      req_dst;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [W-1:0]       rsp_rs_data;
    logic [W-1:0]       rsp_rt_data;
    logic               flush;

    always #5 clk = ~clk;

    regfile_read_unit dut (
        .clk         (clk),
        .reset       (reset),
        .regs_flat   (regs_flat),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_rs      (req_rs),
        .req_rt      (req_rt),
        .req_dst_vld (req_dst_vld),
        .req_dst     (req_dst),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rs_data (rsp_rs_data),
        .rsp_rt_data (rsp_rt_data),
        .flush       (flush)
    );

    // Register file contents as seen by the writer; packed onto regs_flat.
    logic [W-1:0] rf [NREGS];
    always_comb begin
        regs_flat = '0;
        for (int i = 0; i < NREGS; i++) regs_flat[i*W +: W] = rf[i];
    end

    // Reference model state.
    bit           mbusy [NREGS];
    logic         m_valid;
    logic [W-1:0] m_rs;
    logic [W-1:0] m_rt;
    logic         s_ready;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] rd(input logic [AW-1:0] a);
        return (a == '0) ? '0 : rf[a];
    endfunction

    // One clock: writer updates at negedge, ready checked mid-cycle,
    // outputs checked #1 after the posedge.
    task automatic cycle();
        logic hz, e_ready, acc;
        logic [W-1:0] n_rs, n_rt;
        @(negedge clk);
        if (wr_en) rf[wr_addr] = wr_data;
        #1;
        hz = (mbusy[req_rs] && !(wr_en && wr_addr == req_rs)) ||
             (mbusy[req_rt] && !(wr_en && wr_addr == req_rt));
        e_ready = !hz && !flush && (!m_valid || rsp_ready);
        s_ready = req_ready;
        if (!reset) chk("req_ready", {31'b0, req_ready}, {31'b0, e_ready});
        acc  = req_valid && e_ready;
        n_rs = rd(req_rs);
        n_rt = rd(req_rt);
        @(posedge clk);
        if (reset) begin
            foreach (mbusy[i]) mbusy[i] = 1'b0;
            m_valid = 1'b0; m_rs = '0; m_rt = '0;
        end else begin
            if (wr_en) mbusy[wr_addr] = 1'b0;
            if (acc && req_dst_vld && req_dst != '0) mbusy[req_dst] = 1'b1;
            if (acc) begin m_rs = n_rs; m_rt = n_rt; end
            if (flush) begin
                foreach (mbusy[i]) mbusy[i] = 1'b0;
                m_valid = 1'b0;
            end else if (acc) m_valid = 1'b1;
            else if (rsp_ready) m_valid = 1'b0;
        end
        #1;
        chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, m_valid});
        chk("rsp_rs_data", rsp_rs_data, m_rs);
        chk("rsp_rt_data", rsp_rt_data, m_rt);
    endtask

    task automatic drive(input logic v, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                         input logic dv, input logic [AW-1:0] dst);
        req_valid = v; req_rs = rs; req_rt = rt; req_dst_vld = dv; req_dst = dst;
    endtask

    typedef struct {
        logic [AW-1:0] rs;
        logic [AW-1:0] rt;
        logic [W-1:0]  exp_rs;
        logic [W-1:0]  exp_rt;
    } vec_t;
    vec_t tbl [6];

    initial begin
        tbl[0] = '{5'd3,  5'd4,  32'hA5A5_0003, 32'h0000_0004};
        tbl[1] = '{5'd0,  5'd4,  32'h0000_0000, 32'h0000_0004};
        tbl[2] = '{5'd31, 5'd0,  32'hA5A5_001F, 32'h0000_0000};
        tbl[3] = '{5'd17, 5'd17, 32'hA5A5_0011, 32'hA5A5_0011};
        tbl[4] = '{5'd4,  5'd3,  32'h0000_0004, 32'hA5A5_0003};
        tbl[5] = '{5'd1,  5'd30, 32'hA5A5_0001, 32'hA5A5_001E};

        for (int i = 0; i < NREGS; i++) rf[i] = 32'hA5A5_0000 | 32'(i);
        rf[0] = 32'hFFFF_FFFF;
        rf[4] = 32'h0000_0004;
        foreach (mbusy[i]) mbusy[i] = 1'b0;
        m_valid = 1'b0; m_rs = '0; m_rt = '0; s_ready = 1'b0;
        reset = 1'b1; flush = 1'b0; rsp_ready = 1'b1;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        drive(1'b0, '0, '0, 1'b0, '0);
        cycle(); cycle();
        reset = 1'b0;
        chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("reset_rs_data", rsp_rs_data, 32'd0);
        chk("reset_rt_data", rsp_rt_data, 32'd0);
        #1;
        chk("reset_req_ready", {31'b0, req_ready}, 32'd1);

        // Back-to-back reads from the table, one response per cycle.
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, tbl[i].rs, tbl[i].rt, 1'b0, '0);
            cycle();
            chk("tbl_valid", {31'b0, rsp_valid}, 32'd1);
            chk("tbl_rs", rsp_rs_data, tbl[i].exp_rs);
            chk("tbl_rt", rsp_rt_data, tbl[i].exp_rt);
        end

        // RAW stall on dst=5 released by the same-cycle write.
        drive(1'b1, 5'd1, 5'd2, 1'b1, 5'd5); cycle();
        drive(1'b1, 5'd5, 5'd0, 1'b0, '0);
        cycle(); chk("t2_stall_a", {31'b0, s_ready}, 32'd0);
        cycle(); chk("t2_stall_b", {31'b0, s_ready}, 32'd0);
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h5555_1234;
        cycle(); chk("t2_accept_on_write", {31'b0, s_ready}, 32'd1);
        chk("t2_new_data", rsp_rs_data, 32'h5555_1234);
        wr_en = 1'b0;

        // Register 0 reads as zero and is never marked busy.
        drive(1'b1, 5'd0, 5'd0, 1'b1, 5'd0); cycle();
        chk("t3_zero", rsp_rs_data, 32'd0);
        cycle(); chk("t3_no_busy0", {31'b0, s_ready}, 32'd1);

        // Backpressure for three cycles.
        drive(1'b1, 5'd2, 5'd3, 1'b0, '0); cycle();
        rsp_ready = 1'b0;
        drive(1'b1, 5'd6, 5'd7, 1'b0, '0);
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("t4_blocked", {31'b0, s_ready}, 32'd0);
            chk("t4_hold_rs", rsp_rs_data, 32'hA5A5_0002);
            chk("t4_hold_valid", {31'b0, rsp_valid}, 32'd1);
        end
        rsp_ready = 1'b1;
        cycle(); chk("t4_release", {31'b0, s_ready}, 32'd1);
        chk("t4_next_rs", rsp_rs_data, 32'hA5A5_0006);

        // Flush clears busy[7] and the pending response.
        drive(1'b1, 5'd1, 5'd1, 1'b1, 5'd7); cycle();
        drive(1'b1, 5'd7, 5'd0, 1'b0, '0); flush = 1'b1;
        cycle(); chk("t5_flush_ready", {31'b0, s_ready}, 32'd0);
        chk("t5_flush_valid", {31'b0, rsp_valid}, 32'd0);
        flush = 1'b0;
        cycle(); chk("t5_after_flush", {31'b0, s_ready}, 32'd1);
        chk("t5_data", rsp_rs_data, 32'hA5A5_0007);

        // Set beats a same-cycle clear of the same index.
        drive(1'b1, 5'd1, 5'd1, 1'b1, 5'd9);
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h0000_0099;
        cycle(); wr_en = 1'b0;
        drive(1'b1, 5'd9, 5'd0, 1'b0, '0);
        cycle(); chk("t6_set_wins", {31'b0, s_ready}, 32'd0);
        wr_en = 1'b1;
        cycle(); chk("t6_cleared", {31'b0, s_ready}, 32'd1);
        wr_en = 1'b0;

        // Reset during a stalled response.
        drive(1'b1, 5'd1, 5'd2, 1'b1, 5'd11); cycle();
        rsp_ready = 1'b0; drive(1'b1, 5'd11, 5'd0, 1'b0, '0);
        cycle();
        reset = 1'b1; cycle(); reset = 1'b0;
        chk("rst_mid_valid", {31'b0, rsp_valid}, 32'd0);
        cycle(); chk("rst_mid_busy_cleared", {31'b0, s_ready}, 32'd1);
        rsp_ready = 1'b1;

        // Randomized traffic on a small register window to provoke hazards.
        for (int k = 0; k < 500; k++) begin
            req_valid   = ($urandom_range(0, 3) != 0);
            req_rs      = 5'($urandom_range(0, 7));
            req_rt      = 5'($urandom_range(0, 7));
            req_dst_vld = 1'($urandom_range(0, 1));
            req_dst     = 5'($urandom_range(0, 7));
            wr_en       = ($urandom_range(0, 2) == 0);
            wr_addr     = 5'($urandom_range(0, 7));
            wr_data     = $urandom;
            rsp_ready   = ($urandom_range(0, 3) != 0);
            flush       = ($urandom_range(0, 24) == 0);
            reset       = ($urandom_range(0, 79) == 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
